control_sequencer_mc: RTL

- Multicycle successor to the single-cycle control unit. Decodes the same opcode_t/funct_t/aluop_t set, but sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Waits on ihit/dhit. Supports multi-cycle EXEC and a memory-wait timeout.
- Sits between the cache/memory handshake, the datapath (PC, IR, regfile, ALU) and the halt logic.

---
 rtl/control_sequencer_mc.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer_mc.sv
// Multicycle control sequencer: decodes the MIPS-style opcode/funct set and
// walks each instruction through FETCH/DECODE/EXEC/MEM/WB, waiting on the
// instruction and data cache hits with a bounded wait before flagging an error.

package control_sequencer_mc_pkg;
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B, OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08, FN_ADD  = 6'h20,
    FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24,
    FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB  = 4'd3,
    ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR  = 4'd7,
    ALU_SLT = 4'd8, ALU_SLTU = 4'd9
  } aluop_t;
endpackage

module control_sequencer_mc
  import control_sequencer_mc_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int MAX_WAIT    = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        overflow,
  input  logic        negative,
  output logic        imemREN,
  output logic        irWEN,
  output logic        pcWEN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        RegWEN,
  output logic [1:0]  RegDest,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  tmpPC,
  output logic        ALUSrc,
  output logic        ExtOp,
  output logic        lui,
  output aluop_t      ALUOP,
  output logic        halt,
  output logic        memerr,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB    = 3'd4, S_HALT   = 3'd5, S_ERR  = 3'd6
  } state_t;

  localparam logic [3:0]  EXEC_LAST = 4'(EXEC_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  state_t      r_state, w_nxt_state;
  logic [15:0] r_wait, w_nxt_wait;
  logic [3:0]  r_exec, w_nxt_exec;
  logic [5:0]  r_op, r_fn;
  logic        r_ovf;
  logic        w_ir_load, w_ovf_load;

  logic [1:0]  w_dec_rd, w_dec_m2r, w_dec_tpc;
  logic        w_dec_alusrc, w_dec_extop, w_dec_lui;
  aluop_t      w_dec_aluop;
  logic        w_dec_writes, w_dec_ovfchk;
  logic        w_is_jr;

  logic        w_imemren, w_irwen, w_pcwen, w_dmemren, w_dmemwen, w_regwen;
  logic        w_static_en, w_drive;
  logic [1:0]  w_tmppc;

  // Sign and the unused instruction fields are not needed for sequencing.
  logic        w_unused_inputs;
  assign w_unused_inputs = ^{negative, instr[25:6]};

  assign w_is_jr = (r_op == OP_RTYPE) && (r_fn == FN_JR);

  // Static decode of the latched opcode/funct; unknown encodings decode to all-zero (NOP).
  always_comb begin
    w_dec_rd     = 2'd0;
    w_dec_m2r    = 2'd0;
    w_dec_tpc    = 2'd0;
    w_dec_alusrc = 1'b0;
    w_dec_extop  = 1'b0;
    w_dec_lui    = 1'b0;
    w_dec_aluop  = ALU_SLL;
    w_dec_writes = 1'b0;
    w_dec_ovfchk = 1'b0;
    case (r_op)
      OP_RTYPE: begin
        w_dec_rd     = 2'd1;
        w_dec_writes = 1'b1;
        case (r_fn)
          FN_SLL:  w_dec_aluop = ALU_SLL;
          FN_SRL:  w_dec_aluop = ALU_SRL;
          FN_ADD:  begin w_dec_aluop = ALU_ADD; w_dec_ovfchk = 1'b1; end
          FN_ADDU: w_dec_aluop = ALU_ADD;
          FN_SUB:  begin w_dec_aluop = ALU_SUB; w_dec_ovfchk = 1'b1; end
          FN_SUBU: w_dec_aluop = ALU_SUB;
          FN_AND:  w_dec_aluop = ALU_AND;
          FN_OR:   w_dec_aluop = ALU_OR;
          FN_XOR:  w_dec_aluop = ALU_XOR;
          FN_NOR:  w_dec_aluop = ALU_NOR;
          FN_SLT:  w_dec_aluop = ALU_SLT;
          FN_SLTU: w_dec_aluop = ALU_SLTU;
          FN_JR: begin
            w_dec_rd     = 2'd0;
            w_dec_writes = 1'b0;
            w_dec_tpc    = 2'd3;
          end
          default: begin
            w_dec_rd     = 2'd0;
            w_dec_writes = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        w_dec_alusrc = 1'b1; w_dec_extop = 1'b1; w_dec_aluop = ALU_ADD;
        w_dec_writes = 1'b1; w_dec_ovfchk = 1'b1;
      end
      OP_ADDIU: begin
        w_dec_alusrc = 1'b1; w_dec_extop = 1'b1; w_dec_aluop = ALU_ADD; w_dec_writes = 1'b1;
      end
      OP_SLTI: begin
        w_dec_alusrc = 1'b1; w_dec_extop = 1'b1; w_dec_aluop = ALU_SLT; w_dec_writes = 1'b1;
      end
      OP_SLTIU: begin
        w_dec_alusrc = 1'b1; w_dec_extop = 1'b1; w_dec_aluop = ALU_SLTU; w_dec_writes = 1'b1;
      end
      OP_ANDI: begin w_dec_alusrc = 1'b1; w_dec_aluop = ALU_AND; w_dec_writes = 1'b1; end
      OP_ORI:  begin w_dec_alusrc = 1'b1; w_dec_aluop = ALU_OR;  w_dec_writes = 1'b1; end
      OP_XORI: begin w_dec_alusrc = 1'b1; w_dec_aluop = ALU_XOR; w_dec_writes = 1'b1; end
      OP_LUI: begin
        w_dec_alusrc = 1'b1; w_dec_lui = 1'b1; w_dec_aluop = ALU_OR; w_dec_writes = 1'b1;
      end
      OP_LW: begin
        w_dec_alusrc = 1'b1; w_dec_extop = 1'b1; w_dec_aluop = ALU_ADD;
        w_dec_m2r = 2'd1; w_dec_writes = 1'b1;
      end
      OP_SW:  begin w_dec_alusrc = 1'b1; w_dec_extop = 1'b1; w_dec_aluop = ALU_ADD; end
      OP_BEQ: begin w_dec_extop = 1'b1; w_dec_aluop = ALU_SUB; end
      OP_BNE: begin w_dec_extop = 1'b1; w_dec_aluop = ALU_SUB; end
      OP_J:   w_dec_tpc = 2'd2;
      OP_JAL: begin
        w_dec_tpc = 2'd2; w_dec_rd = 2'd2; w_dec_m2r = 2'd2; w_dec_writes = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state, counter updates and strobes for the instruction sequencer.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_wait  = r_wait;
    w_nxt_exec  = r_exec;
    w_ir_load   = 1'b0;
    w_ovf_load  = 1'b0;
    w_imemren   = 1'b0;
    w_irwen     = 1'b0;
    w_pcwen     = 1'b0;
    w_dmemren   = 1'b0;
    w_dmemwen   = 1'b0;
    w_regwen    = 1'b0;
    w_static_en = 1'b0;
    w_tmppc     = w_dec_tpc;
    case (r_state)
      S_FETCH: begin
        w_imemren = 1'b1;
        if (ihit) begin
          w_irwen     = 1'b1;
          w_ir_load   = 1'b1;
          w_nxt_state = S_DECODE;
          w_nxt_wait  = '0;
        end else if (r_wait == WAIT_LAST) begin
          w_nxt_state = S_ERR;
          w_nxt_wait  = '0;
        end else begin
          w_nxt_wait = r_wait + 16'd1;
        end
      end
      S_DECODE: begin
        w_static_en = 1'b1;
        w_nxt_exec  = '0;
        w_nxt_state = (r_op == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        w_static_en = 1'b1;
        if (r_exec == EXEC_LAST) begin
          // Flags are only meaningful on the final EXEC cycle.
          w_nxt_exec = '0;
          w_ovf_load = 1'b1;
          if (r_op == OP_BEQ) begin
            w_tmppc     = zero ? 2'd1 : 2'd0;
            w_pcwen     = 1'b1;
            w_nxt_state = S_FETCH;
          end else if (r_op == OP_BNE) begin
            w_tmppc     = zero ? 2'd0 : 2'd1;
            w_pcwen     = 1'b1;
            w_nxt_state = S_FETCH;
          end else if ((r_op == OP_J) || w_is_jr) begin
            w_pcwen     = 1'b1;
            w_nxt_state = S_FETCH;
          end else if ((r_op == OP_LW) || (r_op == OP_SW)) begin
            w_nxt_state = S_MEM;
          end else begin
            w_nxt_state = S_WB;
          end
        end else begin
          w_nxt_exec = r_exec + 4'd1;
        end
      end
      S_MEM: begin
        w_static_en = 1'b1;
        w_dmemren   = (r_op == OP_LW);
        w_dmemwen   = (r_op == OP_SW);
        if (dhit) begin
          w_nxt_wait = '0;
          if (r_op == OP_SW) begin
            w_pcwen     = 1'b1;
            w_nxt_state = S_FETCH;
          end else begin
            w_nxt_state = S_WB;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_nxt_state = S_ERR;
          w_nxt_wait  = '0;
        end else begin
          w_nxt_wait = r_wait + 16'd1;
        end
      end
      S_WB: begin
        w_static_en = 1'b1;
        w_pcwen     = 1'b1;
        // Signed-add overflow suppresses the register write instead of trapping.
        w_regwen    = w_dec_writes & ~(w_dec_ovfchk & r_ovf);
        w_nxt_state = S_FETCH;
      end
      S_HALT, S_ERR: ;
      default: w_nxt_state = S_FETCH;
    endcase
  end

  // State, counters and IR shadow; all cleared asynchronously on reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_exec  <= '0;
      r_op    <= '0;
      r_fn    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_wait  <= w_nxt_wait;
      r_exec  <= w_nxt_exec;
      if (w_ir_load) begin
        r_op <= instr[31:26];
        r_fn <= instr[5:0];
      end
      if (w_ovf_load) r_ovf <= overflow;
    end
  end

  // Every output is forced low while reset is asserted, including the FETCH read request.
  assign w_drive  = w_static_en & ~RST;
  assign imemREN  = w_imemren & ~RST;
  assign irWEN    = w_irwen & ~RST;
  assign pcWEN    = w_pcwen & ~RST;
  assign dmemREN  = w_dmemren & ~RST;
  assign dmemWEN  = w_dmemwen & ~RST;
  assign RegWEN   = w_regwen & ~RST;
  assign RegDest  = w_drive ? w_dec_rd : 2'd0;
  assign MemtoReg = w_drive ? w_dec_m2r : 2'd0;
  assign tmpPC    = w_drive ? w_tmppc : 2'd0;
  assign ALUSrc   = w_drive & w_dec_alusrc;
  assign ExtOp    = w_drive & w_dec_extop;
  assign lui      = w_drive & w_dec_lui;
  assign ALUOP    = w_drive ? w_dec_aluop : ALU_SLL;
  assign halt     = ~RST & ((r_state == S_HALT) || (r_state == S_ERR));
  assign memerr   = ~RST & (r_state == S_ERR);
  assign state    = r_state;

endmodule
